// File: rtl/qspi_icap_ctrl_if.sv
// Register-strobe bus between the AXI-Lite register adapter and qspi_icap_ctrl.
// Strobe protocol: reg_wr_en/reg_rd_en are one-cycle strobes that are always accepted; reg_rd_ack pulses one cycle after reg_rd_en with reg_rd_data valid in that same cycle.
interface qspi_icap_ctrl_if #(
    parameter int ADDR_WIDTH = 8
) ();
    logic [ADDR_WIDTH-1:0] reg_wr_addr;
    logic [31:0]           reg_wr_data;
    logic [3:0]            reg_wr_strb;
    logic                  reg_wr_en;
    logic [ADDR_WIDTH-1:0] reg_rd_addr;
    logic                  reg_rd_en;
    logic [31:0]           reg_rd_data;
    logic                  reg_rd_ack;

    modport master (
        output reg_wr_addr, reg_wr_data, reg_wr_strb, reg_wr_en,
        output reg_rd_addr, reg_rd_en,
        input  reg_rd_data, reg_rd_ack
    );

    modport slave (
        input  reg_wr_addr, reg_wr_data, reg_wr_strb, reg_wr_en,
        input  reg_rd_addr, reg_rd_en,
        output reg_rd_data, reg_rd_ack
    );
endinterface

// File: rtl/qspi_icap_ctrl.sv
// Byte-oriented QSPI shift engine with TX/RX FIFOs and x1/x2/x4 lanes, plus an
// ICAPE3 reboot sequencer with a programmable warm-boot address.
module qspi_icap_ctrl #(
    parameter int          ADDR_WIDTH     = 8,
    parameter int          FIFO_DEPTH     = 16,
    parameter int          DIV_WIDTH      = 8,
    parameter logic [31:0] WBSTAR_DEFAULT = 32'h0100_0000,
    parameter logic [31:0] BOOT_KEY       = 32'hFEE1_DEAD
) (
    input  logic                   axi_aclk,
    input  logic                   axi_aresetn,
    qspi_icap_ctrl_if.slave        reg_bus,
    output logic                   qspi_clk,
    output logic                   qspi_cs_n,
    output logic [3:0]             qspi_dq_o,
    output logic [3:0]             qspi_dq_oe,
    input  logic [3:0]             qspi_dq_i,
    input  logic                   icap_avail,
    output logic                   icap_csib,
    output logic                   icap_rdwrb,
    output logic [31:0]            icap_di,
    output logic                   irq,
    output logic [1:0]             eng_state,
    output logic [1:0]             icap_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(FIFO_DEPTH);
    localparam int WW = ADDR_WIDTH - 2;
    localparam logic [WW-1:0] W_CTRL   = WW'(0);
    localparam logic [WW-1:0] W_STATUS = WW'(1);
    localparam logic [WW-1:0] W_TXDATA = WW'(2);
    localparam logic [WW-1:0] W_RXDATA = WW'(3);
    localparam logic [WW-1:0] W_WBSTAR = WW'(4);
    localparam logic [WW-1:0] W_REBOOT = WW'(5);
    localparam logic [31:0] CTRL_MASK =
        32'h0000_001F | (((32'd1 << DIV_WIDTH) - 32'd1) << 8);

    typedef enum logic [1:0] {E_IDLE, E_LOAD, E_LOW, E_HIGH} eng_t;
    typedef enum logic [1:0] {I_IDLE, I_WAIT, I_SEND} icap_t;

    // Beat helpers; mode 0 = x1, 1 = x2, 2 = x4.
    function automatic logic [3:0] beat_of(input logic [7:0] sh, input logic [1:0] mode);
        case (mode)
            2'd0:    beat_of = {3'b000, sh[7]};
            2'd1:    beat_of = {2'b00, sh[7:6]};
            default: beat_of = sh[7:4];
        endcase
    endfunction

    function automatic logic [7:0] shift_out(input logic [7:0] sh, input logic [1:0] mode);
        case (mode)
            2'd0:    shift_out = {sh[6:0], 1'b0};
            2'd1:    shift_out = {sh[5:0], 2'b00};
            default: shift_out = {sh[3:0], 4'h0};
        endcase
    endfunction

    // In x1 mode the flash answers on DQ1; wider modes read back on the driven lanes.
    function automatic logic [7:0] sample_in(input logic [7:0] rsh, input logic [3:0] dqi,
                                             input logic [1:0] mode);
        case (mode)
            2'd0:    sample_in = {rsh[6:0], dqi[1]};
            2'd1:    sample_in = {rsh[5:0], dqi[1:0]};
            default: sample_in = {rsh[3:0], dqi};
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] mode);
        case (mode)
            2'd0:    lane_mask = 4'b0001;
            2'd1:    lane_mask = 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] icap_word(input logic [3:0] idx, input logic [31:0] wb);
        case (idx)
            4'd0:    icap_word = 32'hFFFF_FFFF;
            4'd1:    icap_word = 32'hAA99_5566;
            4'd2:    icap_word = 32'h2000_0000;
            4'd3:    icap_word = 32'h3002_0001;
            4'd4:    icap_word = wb;
            4'd5:    icap_word = 32'h3000_8001;
            4'd6:    icap_word = 32'h0000_000F;
            4'd7:    icap_word = 32'h2000_0000;
            4'd8:    icap_word = 32'h2000_0000;
            default: icap_word = 32'hFFFF_FFFF;
        endcase
    endfunction

    // ICAPE3 expects each byte with its bit order swapped.
    function automatic logic [31:0] byte_bitrev(input logic [31:0] w);
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 8; k++) begin
                byte_bitrev[8*b+k] = w[8*b+7-k];
            end
        end
    endfunction

    // Register decode
    logic [WW-1:0] wr_word, rd_word;
    logic          wr_ctrl, wr_status, wr_txdata, wr_wbstar, wr_reboot;
    logic          rd_rxdata;

    assign wr_word   = reg_bus.reg_wr_addr[ADDR_WIDTH-1:2];
    assign rd_word   = reg_bus.reg_rd_addr[ADDR_WIDTH-1:2];
    assign wr_ctrl   = reg_bus.reg_wr_en && (wr_word == W_CTRL);
    assign wr_status = reg_bus.reg_wr_en && (wr_word == W_STATUS);
    assign wr_txdata = reg_bus.reg_wr_en && (wr_word == W_TXDATA);
    assign wr_wbstar = reg_bus.reg_wr_en && (wr_word == W_WBSTAR);
    assign wr_reboot = reg_bus.reg_wr_en && (wr_word == W_REBOOT);
    assign rd_rxdata = reg_bus.reg_rd_en && (rd_word == W_RXDATA);

    logic unused_bits;
    assign unused_bits = ^{reg_bus.reg_wr_addr[1:0], reg_bus.reg_rd_addr[1:0]};

    logic [31:0]          ctrl_q, wbstar_q;
    logic                 en, ie;
    logic [1:0]           mode_sel;
    logic [DIV_WIDTH-1:0] div;

    assign en       = ctrl_q[0];
    assign ie       = ctrl_q[4];
    assign div      = ctrl_q[8 +: DIV_WIDTH];
    assign mode_sel = ctrl_q[3] ? 2'd2 : (ctrl_q[2] ? 2'd1 : 2'd0);
    assign qspi_cs_n = ~ctrl_q[1];

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            ctrl_q   <= '0;
            wbstar_q <= WBSTAR_DEFAULT;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr_ctrl && reg_bus.reg_wr_strb[i])
                    ctrl_q[8*i +: 8] <= reg_bus.reg_wr_data[8*i +: 8] & CTRL_MASK[8*i +: 8];
                if (wr_wbstar && reg_bus.reg_wr_strb[i])
                    wbstar_q[8*i +: 8] <= reg_bus.reg_wr_data[8*i +: 8];
            end
        end
    end

    // FIFOs: pointers carry one extra wrap bit so full and empty are distinct.
    logic [9:0] tx_mem [FIFO_DEPTH];
    logic [7:0] rx_mem [FIFO_DEPTH];
    logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp, tx_level, rx_level;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_pop, tx_push, rx_pop, rx_push, rx_push_req;

    assign tx_level = tx_wp - tx_rp;
    assign rx_level = rx_wp - rx_rp;
    assign tx_empty = (tx_level == '0);
    assign rx_empty = (rx_level == '0);
    assign tx_full  = (tx_level == DEPTH_L);
    assign rx_full  = (rx_level == DEPTH_L);
    assign rx_pop   = rd_rxdata && !rx_empty;
    assign tx_push  = wr_txdata && (!tx_full || tx_pop);
    assign rx_push  = rx_push_req && (!rx_full || rx_pop);

    logic [7:0] rx_sh;

    always_ff @(posedge axi_aclk) begin
        if (tx_push) tx_mem[tx_wp[AW-1:0]] <= reg_bus.reg_wr_data[9:0];
        if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_sh;
    end

    logic ovf_q, ovf_set, ovf_clr;
    assign ovf_set = (wr_txdata && tx_full && !tx_pop) || (rx_push_req && rx_full && !rx_pop);
    assign ovf_clr = wr_status && reg_bus.reg_wr_strb[0] && reg_bus.reg_wr_data[5];

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            ovf_q <= ovf_set || (ovf_q && !ovf_clr);
        end
    end

    // Shift engine
    eng_t                 eng_q, eng_d;
    logic [DIV_WIDTH-1:0] cnt, cur_div;
    logic [3:0]           beats;
    logic [7:0]           tx_sh;
    logic [1:0]           cur_mode;
    logic                 cur_dir, cur_cap, busy, phase_done, last_beat;

    assign phase_done = (cnt == '0);
    assign last_beat  = (beats == 4'd1);

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) eng_q <= E_IDLE;
        else              eng_q <= eng_d;
    end

    always_comb begin
        eng_d = eng_q;
        case (eng_q)
            E_IDLE:  if (tx_pop) eng_d = E_LOAD;
            E_LOAD:  eng_d = E_LOW;
            E_LOW:   if (phase_done) eng_d = E_HIGH;
            E_HIGH:  if (phase_done) eng_d = last_beat ? E_IDLE : E_LOW;
            default: eng_d = E_IDLE;
        endcase
    end

    always_comb begin
        tx_pop      = (eng_q == E_IDLE) && en && !tx_empty;
        busy        = (eng_q != E_IDLE) || tx_pop;
        qspi_clk    = (eng_q == E_HIGH);
        rx_push_req = (eng_q == E_HIGH) && phase_done && last_beat && cur_cap;
    end

    // Datapath; dq_o/dq_oe only change inside a byte so they hold between bytes.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            cnt        <= '0;
            cur_div    <= '0;
            beats      <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            cur_mode   <= '0;
            cur_dir    <= 1'b0;
            cur_cap    <= 1'b0;
            qspi_dq_o  <= '0;
            qspi_dq_oe <= '0;
        end else begin
            case (eng_q)
                E_IDLE: begin
                    if (tx_pop) begin
                        {cur_dir, cur_cap, tx_sh} <= tx_mem[tx_rp[AW-1:0]];
                        cur_mode <= mode_sel;
                        cur_div  <= div;
                    end
                end
                E_LOAD: begin
                    beats      <= (cur_mode == 2'd0) ? 4'd8 : ((cur_mode == 2'd1) ? 4'd4 : 4'd2);
                    qspi_dq_oe <= cur_dir ? 4'b0000 : lane_mask(cur_mode);
                    qspi_dq_o  <= beat_of(tx_sh, cur_mode);
                    tx_sh      <= shift_out(tx_sh, cur_mode);
                    rx_sh      <= '0;
                    cnt        <= cur_div;
                end
                E_LOW: begin
                    if (phase_done) begin
                        cnt   <= cur_div;
                        rx_sh <= sample_in(rx_sh, qspi_dq_i, cur_mode);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                E_HIGH: begin
                    if (phase_done) begin
                        cnt   <= cur_div;
                        beats <= beats - 1'b1;
                        if (!last_beat) begin
                            qspi_dq_o <= beat_of(tx_sh, cur_mode);
                            tx_sh     <= shift_out(tx_sh, cur_mode);
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ICAP sequencer; word 0 goes out combinationally in the cycle AVAIL is seen.
    icap_t       icap_q, icap_d;
    logic [3:0]  icap_idx;
    logic [31:0] wb_lat;
    logic        icap_trig, icap_active;

    assign icap_trig = wr_reboot && (reg_bus.reg_wr_data == BOOT_KEY) &&
                       (reg_bus.reg_wr_strb == 4'hF) && (icap_q == I_IDLE);

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) icap_q <= I_IDLE;
        else              icap_q <= icap_d;
    end

    always_comb begin
        icap_d = icap_q;
        case (icap_q)
            I_IDLE:  if (icap_trig) icap_d = I_WAIT;
            I_WAIT:  if (icap_avail) icap_d = I_SEND;
            I_SEND:  if (icap_idx == 4'd8) icap_d = I_IDLE;
            default: icap_d = I_IDLE;
        endcase
    end

    always_comb begin
        icap_active = (icap_q == I_SEND) || ((icap_q == I_WAIT) && icap_avail);
        icap_csib   = !icap_active;
        icap_rdwrb  = 1'b0;
        icap_di     = 32'hFFFF_FFFF;
        if (icap_q == I_SEND) icap_di = byte_bitrev(icap_word(icap_idx, wb_lat));
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            icap_idx <= '0;
            wb_lat   <= '0;
        end else begin
            if (icap_trig) wb_lat <= wbstar_q;
            case (icap_q)
                I_WAIT:  icap_idx <= 4'd1;
                I_SEND:  icap_idx <= icap_idx + 1'b1;
                default: icap_idx <= '0;
            endcase
        end
    end

    // Read path
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (rd_word)
            W_CTRL:   rd_mux = ctrl_q;
            W_STATUS: rd_mux = {8'h00, 8'(rx_level), 8'(tx_level), 2'b00, ovf_q,
                                rx_empty, rx_full, tx_empty, tx_full, busy};
            W_RXDATA: rd_mux = rx_empty ? 32'h0 : {1'b1, 23'h0, rx_mem[rx_rp[AW-1:0]]};
            W_WBSTAR: rd_mux = wbstar_q;
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            reg_bus.reg_rd_data <= '0;
            reg_bus.reg_rd_ack  <= 1'b0;
        end else begin
            reg_bus.reg_rd_ack <= reg_bus.reg_rd_en;
            if (reg_bus.reg_rd_en) reg_bus.reg_rd_data <= rd_mux;
        end
    end

    assign irq        = ie && tx_empty && !busy;
    assign eng_state  = eng_q;
    assign icap_state = icap_q;

endmodule
